// File: rtl/result_drain_streamer_pkg.sv
// -----------------------------------------------------------------------------
// result_drain_streamer_pkg
//   Shared definitions for the result-drain path: default geometry of the TPU
//   core result SRAM, drain FSM state encoding, and small sizing helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package result_drain_streamer_pkg;

    // Geometry defaults shared with the core.
    localparam int PSB                 = 24;   // bits per partial sum
    localparam int DEFAULT_MATRIX_SIZE = 64;   // partial sums per SRAM row
    localparam int DEFAULT_LANES       = 4;    // partial sums per output beat
    localparam int DEFAULT_ADDRESSSIZE = 10;   // result-SRAM address width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } drain_state_t;

    // Ceil(log2(value)), never narrower than one bit so a counter always exists.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int beats_of(input int matrix_size, input int lanes);
        return matrix_size / lanes;
    endfunction

    localparam int BEATS = beats_of(DEFAULT_MATRIX_SIZE, DEFAULT_LANES);

endpackage

// File: rtl/result_drain_streamer_if.sv
// -----------------------------------------------------------------------------
// result_drain_streamer_if
//   Valid/ready beat stream from the result drainer toward the host/DMA.
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  sink ready
//   out_data   master->slave  LANES partial sums, element k at [k*PSB +: PSB]
//   out_last   master->slave  final beat of the final row of a drain
// -----------------------------------------------------------------------------
interface result_drain_streamer_if
    import result_drain_streamer_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = PSB,
    parameter int LANES          = DEFAULT_LANES
) ();

    logic                              out_valid;
    logic                              out_ready;
    logic [PARTIAL_SUM_BW*LANES-1:0]   out_data;
    logic                              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/result_drain_streamer_row_serializer.sv
// -----------------------------------------------------------------------------
// result_drain_streamer_row_serializer
//   Loadable wide shift register holding one SRAM row. The low LANES elements
//   are always presented as the current beat; each shift drops them and moves
//   the next group down.
//   clk, rst   clock, synchronous active-high reset (clears row and index)
//   load       capture load_data, restart beat index at 0
//   load_data  full SRAM row, element 0 in the LSBs
//   shift      advance to the next beat
//   beat_data  current beat (low LANES elements of the held row)
//   beat_idx   index of the current beat within the row
// -----------------------------------------------------------------------------
module result_drain_streamer_row_serializer
    import result_drain_streamer_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = PSB,
    parameter int MATRIX_SIZE    = DEFAULT_MATRIX_SIZE,
    parameter int LANES          = DEFAULT_LANES,
    localparam int ROW_W         = PARTIAL_SUM_BW * MATRIX_SIZE,
    localparam int BEAT_W        = PARTIAL_SUM_BW * LANES,
    localparam int NBEATS        = beats_of(MATRIX_SIZE, LANES),
    localparam int BEAT_IDX_W    = clog2_min1(NBEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ROW_W-1:0]      load_data,
    input  logic                  shift,
    output logic [BEAT_W-1:0]     beat_data,
    output logic [BEAT_IDX_W-1:0] beat_idx
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NBEATS - 1);
    localparam logic [BEAT_IDX_W-1:0] ONE_BEAT  = BEAT_IDX_W'(1);

    logic [ROW_W-1:0]      row_q;
    logic [BEAT_IDX_W-1:0] beat_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            beat_idx_q <= '0;
        end else if (load) begin
            row_q      <= load_data;
            beat_idx_q <= '0;
        end else if (shift) begin
            row_q <= row_q >> BEAT_W;
            // Hold on the final beat so the index never wraps inside a row.
            if (beat_idx_q != LAST_BEAT) begin
                beat_idx_q <= beat_idx_q + ONE_BEAT;
            end
        end
    end

    assign beat_data = row_q[BEAT_W-1:0];
    assign beat_idx  = beat_idx_q;

endmodule

// File: rtl/result_drain_streamer.sv
// -----------------------------------------------------------------------------
// result_drain_streamer
//   Drains num_rows rows of the result SRAM starting at base_addr and streams
//   each row out as MATRIX_SIZE/LANES beats of LANES partial sums. Data passes
//   through bit-exact. Owns the SRAM read port while busy.
//   clk, rst    clock, synchronous active-high reset (aborts a drain)
//   start       one-cycle pulse, accepted only in IDLE
//   base_addr   first row address, sampled on the accepted start
//   num_rows    row count, sampled on the accepted start (0 = done only)
//   rd_en       SRAM read strobe (one cycle per row)
//   rd_addr     SRAM read address, base_addr+row wrapping mod 2^ADDRESSSIZE
//   rd_data     SRAM row, valid the cycle after rd_en
//   busy        high from the accepted start until the done cycle
//   done        one-cycle completion pulse
//   stream      beat stream (out_valid/out_ready/out_data/out_last)
// -----------------------------------------------------------------------------
module result_drain_streamer
    import result_drain_streamer_pkg::*;
#(
    parameter int ADDRESSSIZE    = DEFAULT_ADDRESSSIZE,
    parameter int MATRIX_SIZE    = DEFAULT_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = PSB,
    parameter int LANES          = DEFAULT_LANES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ADDRESSSIZE-1:0]                 base_addr,
    input  logic [ADDRESSSIZE:0]                   num_rows,
    output logic                                   rd_en,
    output logic [ADDRESSSIZE-1:0]                 rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  rd_data,
    output logic                                   busy,
    output logic                                   done,
    result_drain_streamer_if.master                stream
);

    localparam int NBEATS     = beats_of(MATRIX_SIZE, LANES);
    localparam int BEAT_IDX_W = clog2_min1(NBEATS);
    localparam int BEAT_W     = PARTIAL_SUM_BW * LANES;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NBEATS - 1);
    localparam logic [ADDRESSSIZE:0]  ONE_ROW   = (ADDRESSSIZE + 1)'(1);

    drain_state_t state, state_nx;

    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE:0]   num_q;
    logic [ADDRESSSIZE:0]   row_idx;

    logic                   load;
    logic                   shift;
    logic                   send_vld;
    logic                   beat_is_last;
    logic                   row_last;
    logic [BEAT_W-1:0]      beat_data;
    logic [BEAT_IDX_W-1:0]  beat_idx;

    assign beat_is_last = (beat_idx == LAST_BEAT);
    assign row_last     = (row_idx == num_q - ONE_ROW);
    assign shift        = send_vld & stream.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Drain parameters are latched once per drain; later changes on the
    // inputs, including re-pulsed starts, are deliberately not observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            num_q   <= '0;
            row_idx <= '0;
        end else if (state == IDLE && start) begin
            base_q  <= base_addr;
            num_q   <= num_rows;
            row_idx <= '0;
        end else if (shift && beat_is_last && !row_last) begin
            row_idx <= row_idx + ONE_ROW;
        end
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        load     = 1'b0;
        send_vld = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (num_rows != '0) ? READ : FIN;
                end
            end
            READ: begin
                rd_en    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                // SRAM data is valid this cycle; it lands in the row buffer at the edge.
                load     = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                send_vld = 1'b1;
                if (stream.out_ready && beat_is_last) begin
                    state_nx = row_last ? FIN : READ;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address adds in ADDRESSSIZE bits so the row index wraps silently.
    assign rd_addr = rd_en ? (base_q + row_idx[ADDRESSSIZE-1:0]) : '0;

    // Busy includes the accepting start cycle, so an empty drain still shows
    // one busy cycle before its done pulse.
    assign busy = (state == IDLE && start && !rst) ||
                  (state == READ) || (state == WAIT) || (state == SEND);

    // Valid and data come only from registered state, never from out_ready.
    assign stream.out_valid = send_vld;
    assign stream.out_data  = send_vld ? beat_data : '0;
    assign stream.out_last  = send_vld & row_last & beat_is_last;

    result_drain_streamer_row_serializer #(
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .MATRIX_SIZE    (MATRIX_SIZE),
        .LANES          (LANES)
    ) u_row_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (rd_data),
        .shift     (shift),
        .beat_data (beat_data),
        .beat_idx  (beat_idx)
    );

endmodule

// File: tb/tb_result_drain_streamer.sv
// -----------------------------------------------------------------------------
// tb_result_drain_streamer
//   Scoreboard bench: each drain pushes its expected SRAM addresses and beats
//   (computed from a row-array memory image) into queues; a negedge monitor
//   pops and compares whenever the DUT reads or hands a beat over.
// -----------------------------------------------------------------------------
module tb_result_drain_streamer;

    localparam int AW = 10;
    localparam int MS = 64;
    localparam int PW = 24;
    localparam int LN = 4;
    localparam int NB = MS / LN;
    localparam int BW = PW * LN;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       num_rows;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [PW*MS-1:0]  rd_data;
    logic              busy;
    logic              done;

    result_drain_streamer_if #(.PARTIAL_SUM_BW(PW), .LANES(LN)) stream ();

    result_drain_streamer #(
        .ADDRESSSIZE    (AW),
        .MATRIX_SIZE    (MS),
        .PARTIAL_SUM_BW (PW),
        .LANES          (LN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .stream    (stream)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [PW-1:0] mem [0:1023][0:MS-1];

    int n_cmp      = 0;
    int n_fail     = 0;
    int beat_total = 0;
    int ready_pct  = 100;
    bit abort_f    = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SRAM: row appears the cycle after rd_en; junk otherwise so late capture shows.
    always @(posedge clk) begin
        for (int k = 0; k < MS; k++) begin
            rd_data[k*PW +: PW] <= rd_en ? mem[rd_addr][k] : PW'($urandom);
        end
    end

    initial begin
        stream.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stream.out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor
    logic          prev_stall = 1'b0;
    logic          prev_done  = 1'b0;
    logic [BW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (prev_done) check("done_one_cycle", done, 0);
        prev_done <= done;
        if (rst || abort_f) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", stream.out_valid, 1);
                check("hold_data", stream.out_data, prev_data);
                check("hold_last", stream.out_last, prev_last);
            end
            if (!stream.out_valid) check("last_without_valid", stream.out_last, 0);
            if (rd_en) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_rd_en", 1, 0);
                end else begin
                    check("rd_addr", rd_addr, addr_q[0]);
                    void'(addr_q.pop_front());
                end
            end
            if (stream.out_valid && stream.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("beat_data", stream.out_data, exp_q[0].data);
                    check("beat_last", stream.out_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                beat_total <= beat_total + 1;
            end
            prev_stall <= stream.out_valid && !stream.out_ready;
            prev_data  <= stream.out_data;
            prev_last  <= stream.out_last;
        end
    end

    // Reference: row r of the drain is memory row (base+r) mod 1024; beat b
    // carries elements b*LANES .. b*LANES+LANES-1 with the lowest in the LSBs.
    task automatic push_expect(input logic [AW-1:0] b, input int n);
        for (int r = 0; r < n; r++) begin
            logic [AW-1:0] a;
            a = b + AW'(r);
            addr_q.push_back(a);
            for (int bb = 0; bb < NB; bb++) begin
                beat_t e;
                for (int l = 0; l < LN; l++) e.data[l*PW +: PW] = mem[a][bb*LN + l];
                e.last = (r == n - 1) && (bb == NB - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1; abort_f = 1'b1; start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        abort_f = 1'b0;
    endtask

    // k counts cycles from the start cycle (k=0). Returns at the done cycle.
    task automatic run_drain(input logic [AW-1:0] b, input int n, input bit spam,
                             output int first_rd, output int first_vld,
                             output int last_k, output int done_k, output int busy_cnt);
        int k, rd_cnt, beats0, limit;
        beats0 = beat_total;
        @(posedge clk);
        #1;
        base_addr = b;
        num_rows  = (AW+1)'(n);
        start     = 1'b1;
        push_expect(b, n);
        k = 0; rd_cnt = 0; busy_cnt = 0;
        first_rd = -1; first_vld = -1; last_k = -1; done_k = -1;
        limit = 40 + n * NB * 12;
        while (done_k < 0 && k < limit) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = k;
            end
            if (stream.out_valid && first_vld < 0) first_vld = k;
            if (stream.out_valid && stream.out_ready && stream.out_last) last_k = k;
            if (done) begin
                done_k = k;
                check("busy_low_at_done", busy, 0);
            end else begin
                @(posedge clk);
                #1;
                start = spam && (k >= 4);
                if (spam) begin
                    base_addr = AW'($urandom);
                    num_rows  = (AW+1)'($urandom_range(1, 9));
                end
                k++;
            end
        end
        if (done_k < 0) begin
            check("drain_timeout", 0, 1);
            hard_reset();
        end else begin
            check("rows_read", rd_cnt, n);
            check("beat_count", beat_total - beats0, NB * n);
            check("beats_outstanding", exp_q.size(), 0);
            check("reads_outstanding", addr_q.size(), 0);
        end
        if (start) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic run_abort(input logic [AW-1:0] b, input int n);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        base_addr = b; num_rows = (AW+1)'(n); start = 1'b1;
        push_expect(b, n);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!stream.out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_reached_send", stream.out_valid, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; abort_f = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", stream.out_valid, 0);
        check("abort_out_last", stream.out_last, 0);
        check("abort_out_data", stream.out_data, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_abort", done, 0);
            check("idle_after_abort", busy, 0);
        end
        abort_f = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached (%0d compared, %0d mismatched)", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int f_rd, f_vld, l_k, d_k, b_cnt;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
        for (int a = 0; a < 1024; a++)
            for (int k = 0; k < MS; k++) mem[a][k] = PW'($urandom);
        for (int i = 0; i < MS; i++) mem[0][i] = PW'(i);
        for (int i = 0; i < MS; i++) begin
            case (i % 4)
                0: mem[5][i] = 24'hFFFFFF;
                1: mem[5][i] = 24'h800000;
                2: mem[5][i] = 24'h7FFFFF;
                default: mem[5][i] = 24'h000001;
            endcase
        end

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", stream.out_valid, 0);
        check("rst_out_data", stream.out_data, 0);
        check("rst_out_last", stream.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single row of 0..63, always ready: exact latencies
        ready_pct = 100;
        run_drain(10'h000, 1, 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t1_first_rd_cycle", f_rd, 1);
        check("t1_first_valid_cycle", f_vld, 3);
        check("t1_last_beat_cycle", l_k, 18);
        check("t1_done_cycle", d_k, 19);
        check("t1_busy_cycles", b_cnt, 19);

        // Three rows wrapping past the top of the address space
        run_drain(10'h3FF, 3, 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t2_last_beat_cycle", l_k, 54);
        check("t2_done_cycle", d_k, 55);

        // Random backpressure, random bases and lengths
        ready_pct = 40;
        for (int t = 0; t < 6; t++) begin
            run_drain(AW'($urandom), $urandom_range(1, 4), 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
            check("t3_first_rd_cycle", f_rd, 1);
        end

        // Empty drain
        ready_pct = 100;
        repeat (2) begin @(posedge clk); #1; end
        run_drain(AW'($urandom), 0, 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t4_no_reads", f_rd, -1);
        check("t4_done_cycle", d_k, 1);
        check("t4_busy_cycles", b_cnt, 1);

        // Start held through the drain and its done cycle with changing inputs
        run_drain(10'h123, 2, 1'b1, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t5_done_cycle", d_k, 37);
        repeat (4) begin
            @(negedge clk);
            check("t5_no_restart_rd", rd_en, 0);
            check("t5_no_restart_busy", busy, 0);
        end

        // Abort in SEND, then a fresh drain
        run_abort(10'h040, 3);
        run_drain(10'h041, 2, 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t5_after_abort_first_rd", f_rd, 1);
        check("t5_after_abort_done", d_k, 37);

        // Signed extremes, then a start in the cycle right after done
        run_drain(10'h005, 1, 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t6_done_cycle", d_k, 19);
        run_drain(10'h006, 2, 1'b0, f_rd, f_vld, l_k, d_k, b_cnt);
        check("t6_b2b_first_rd", f_rd, 1);
        check("t6_b2b_done", d_k, 37);

        repeat (3) begin @(posedge clk); #1; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
